// File: rtl/rr_arb_mux_if.sv
// rtl/rr_arb_mux_if.sv - channel inputs, output word and status bundle for rr_arb_mux
interface rr_arb_mux_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] i_in_data;
  logic [CHANNELS-1:0]       i_in_valid;
  logic [CHANNELS-1:0]       o_in_ready;
  logic [WIDTH-1:0]          o_out_data;
  logic                      o_out_valid;
  logic                      i_out_ready;
  logic [SEL_W-1:0]          o_out_sel;
  logic [15:0]               o_grant_count;

  // arbiter side
  modport slave (
    input  i_in_data, i_in_valid, i_out_ready,
    output o_in_ready, o_out_data, o_out_valid, o_out_sel, o_grant_count
  );

  // producer/consumer side
  modport master (
    output i_in_data, i_in_valid, i_out_ready,
    input  o_in_ready, o_out_data, o_out_valid, o_out_sel, o_grant_count
  );
endinterface

// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - round-robin / fixed-priority N:1 arbiter with a registered output word
module rr_arb_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int MODE     = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  rr_arb_mux_if.slave bus
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [SEL_W-1:0]    r_ptr;
  logic [SEL_W-1:0]    r_out_sel;
  logic [WIDTH-1:0]    r_out_data;
  logic                r_out_valid;
  logic [15:0]         r_grant_count;

  logic                w_load;
  logic                w_found;
  logic                w_xfer;
  logic [SEL_W-1:0]    w_winner;
  logic [WIDTH-1:0]    w_win_data;
  logic [CHANNELS-1:0] w_in_ready;

  // output register can take a new word when empty or being drained this cycle
  assign w_load = !r_out_valid || bus.i_out_ready;
  // no transfer may happen while reset is held, even though load is true then
  assign w_xfer = i_rst_n && w_load && w_found;

  // winner search: first pass covers channels at or above ptr, second pass wraps to the lowest
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (!w_found && bus.i_in_valid[c] && (SEL_W'(c) >= r_ptr)) begin
        w_found  = 1'b1;
        w_winner = SEL_W'(c);
      end
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (!w_found && bus.i_in_valid[c]) begin
        w_found  = 1'b1;
        w_winner = SEL_W'(c);
      end
    end
  end

  // one-hot ready and data select; only the winning lane is read so X on idle lanes cannot leak
  always_comb begin
    w_in_ready = '0;
    w_win_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_winner == SEL_W'(c)) begin
        w_in_ready[c] = w_xfer;
        w_win_data    = bus.i_in_data[c*WIDTH +: WIDTH];
      end
    end
  end

  // output word, rotation pointer and transfer counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_sel     <= '0;
      r_ptr         <= '0;
      r_grant_count <= '0;
    end else if (w_load) begin
      if (w_xfer) begin
        r_out_valid   <= 1'b1;
        r_out_data    <= w_win_data;
        r_out_sel     <= w_winner;
        r_grant_count <= r_grant_count + 16'd1;
        if (MODE == 1) begin
          r_ptr <= (w_winner == SEL_W'(CHANNELS - 1)) ? '0 : w_winner + 1'b1;
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.o_in_ready    = w_in_ready;
  assign bus.o_out_data    = r_out_data;
  assign bus.o_out_valid   = r_out_valid;
  assign bus.o_out_sel     = r_out_sel;
  assign bus.o_grant_count = r_grant_count;
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - scoreboard bench for rr_arb_mux (round-robin, fixed priority, 3-channel wrap)
module tb_rr_arb_mux;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;

  rr_arb_mux_if #(.WIDTH(8), .CHANNELS(4)) bus_a ();
  rr_arb_mux_if #(.WIDTH(8), .CHANNELS(4)) bus_b ();
  rr_arb_mux_if #(.WIDTH(8), .CHANNELS(3)) bus_c ();

  rr_arb_mux #(.WIDTH(8), .CHANNELS(4), .MODE(1)) dut_a (.i_clk(clk), .i_rst_n(rst_a), .bus(bus_a));
  rr_arb_mux #(.WIDTH(8), .CHANNELS(4), .MODE(0)) dut_b (.i_clk(clk), .i_rst_n(rst_b), .bus(bus_b));
  rr_arb_mux #(.WIDTH(8), .CHANNELS(3), .MODE(1)) dut_c (.i_clk(clk), .i_rst_n(rst_c), .bus(bus_c));

  int n_chk  = 0;
  int n_pass = 0;

  // expected words: {6'b0, sel[1:0], data[7:0]}
  logic [15:0] q_a[$];
  logic [15:0] q_b[$];
  logic [15:0] q_c[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic extra(input string name, input logic [15:0] word);
    n_chk++;
    $display("FAIL %s: got word %0h expected no word", name, word);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitors: a word is compared when the consumer takes it
  always @(negedge clk) begin
    if (rst_a && bus_a.o_out_valid && bus_a.i_out_ready) begin
      if (q_a.size() == 0) extra("a_extra_word", {6'd0, bus_a.o_out_sel, bus_a.o_out_data});
      else check("a_word", {22'd0, bus_a.o_out_sel, bus_a.o_out_data}, {16'd0, q_a.pop_front()});
    end
    if (rst_b && bus_b.o_out_valid && bus_b.i_out_ready) begin
      if (q_b.size() == 0) extra("b_extra_word", {6'd0, bus_b.o_out_sel, bus_b.o_out_data});
      else check("b_word", {22'd0, bus_b.o_out_sel, bus_b.o_out_data}, {16'd0, q_b.pop_front()});
    end
    if (rst_c && bus_c.o_out_valid && bus_c.i_out_ready) begin
      if (q_c.size() == 0) extra("c_extra_word", {6'd0, bus_c.o_out_sel, bus_c.o_out_data});
      else check("c_word", {22'd0, bus_c.o_out_sel, bus_c.o_out_data}, {16'd0, q_c.pop_front()});
    end
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    bus_a.i_in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus_a.i_in_valid = 4'hF;
    bus_a.i_out_ready = 1'b1;
    bus_b.i_in_data = '0; bus_b.i_in_valid = '0; bus_b.i_out_ready = 1'b1;
    bus_c.i_in_data = '0; bus_c.i_in_valid = '0; bus_c.i_out_ready = 1'b1;
    #1;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    #2;

    // reset state, with all inputs requesting
    check("a_rst_valid", bus_a.o_out_valid, 0);
    check("a_rst_data", bus_a.o_out_data, 0);
    check("a_rst_sel", bus_a.o_out_sel, 0);
    check("a_rst_count", bus_a.o_grant_count, 0);
    check("a_rst_in_ready", bus_a.o_in_ready, 0);
    tick();
    tick();
    check("a_rst_hold_valid", bus_a.o_out_valid, 0);
    check("a_rst_hold_count", bus_a.o_grant_count, 0);
    rst_b = 1'b1; rst_c = 1'b1;

    // round-robin fairness: 0,1,2,3,0,1
    for (int k = 0; k < 6; k++) q_a.push_back({6'd0, 2'(k % 4), 8'hA0 + 8'(k % 4)});
    rst_a = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("a_rr_count", bus_a.o_grant_count, k);
      check("a_rr_sel", bus_a.o_out_sel, (k - 1) % 4);
      check("a_rr_in_ready", bus_a.o_in_ready, 4'b0001 << (k % 4));
    end
    bus_a.i_in_valid = 4'h0;
    tick();
    check("a_idle_valid", bus_a.o_out_valid, 0);
    check("a_idle_sel_hold", bus_a.o_out_sel, 1);
    check("a_idle_data_hold", bus_a.o_out_data, 8'hA1);

    // backpressure: A (ch0) held 3 cycles, then B (ch1) loads on the draining edge
    bus_a.i_out_ready = 1'b0;
    bus_a.i_in_data = {8'hA3, 8'hA2, 8'h6B, 8'h5A};
    bus_a.i_in_valid = 4'b0011;
    q_a.push_back({6'd0, 2'd0, 8'h5A});
    tick();
    for (int k = 0; k < 3; k++) begin
      check("a_bp_data", bus_a.o_out_data, 8'h5A);
      check("a_bp_in_ready", bus_a.o_in_ready, 0);
      tick();
    end
    check("a_bp_data_last", bus_a.o_out_data, 8'h5A);
    check("a_bp_valid", bus_a.o_out_valid, 1);
    bus_a.i_out_ready = 1'b1;
    q_a.push_back({6'd0, 2'd1, 8'h6B});
    #1;
    check("a_bp_release_ready", bus_a.o_in_ready, 4'b0010);
    tick();
    check("a_bp_b_data", bus_a.o_out_data, 8'h6B);
    check("a_bp_b_valid", bus_a.o_out_valid, 1);
    check("a_bp_count", bus_a.o_grant_count, 8);
    bus_a.i_in_valid = 4'h0;
    tick();

    // reset while a word is held
    bus_a.i_out_ready = 1'b0;
    bus_a.i_in_data[7:0] = 8'h77;
    bus_a.i_in_valid = 4'b0001;
    tick();
    check("a_mh_valid_before", bus_a.o_out_valid, 1);
    check("a_mh_count_before", bus_a.o_grant_count, 9);
    #2;
    rst_a = 1'b0;
    #1;
    check("a_mh_valid", bus_a.o_out_valid, 0);
    check("a_mh_count", bus_a.o_grant_count, 0);
    check("a_mh_data", bus_a.o_out_data, 0);
    check("a_mh_in_ready", bus_a.o_in_ready, 0);
    tick();
    check("a_mh_no_xfer", bus_a.o_grant_count, 0);
    bus_a.i_in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus_a.i_in_valid = 4'hF;
    bus_a.i_out_ready = 1'b1;
    q_a.push_back({6'd0, 2'd0, 8'hA0});
    rst_a = 1'b1;
    tick();
    check("a_post_rst_sel", bus_a.o_out_sel, 0);
    check("a_post_rst_count", bus_a.o_grant_count, 1);
    bus_a.i_in_valid = 4'h0;
    tick();

    // counter wrap after 65536 transfers
    rst_a = 1'b0;
    #1;
    rst_a = 1'b1;
    for (int k = 0; k <= 65536; k++) q_a.push_back({6'd0, 2'(k % 4), 8'hA0 + 8'(k % 4)});
    bus_a.i_in_valid = 4'hF;
    repeat (65536) tick();
    check("a_wrap_count0", bus_a.o_grant_count, 0);
    tick();
    check("a_wrap_count1", bus_a.o_grant_count, 1);
    check("a_wrap_sel", bus_a.o_out_sel, 0);
    bus_a.i_in_valid = 4'h0;
    tick();

    // fixed priority with X on idle lanes
    bus_b.i_in_data = {8'h33, 8'hxx, 8'h11, 8'hxx};
    bus_b.i_in_valid = 4'b1010;
    for (int k = 0; k < 5; k++) q_b.push_back({6'd0, 2'd1, 8'h11});
    for (int k = 0; k < 5; k++) begin
      #1;
      check("b_fp_in_ready", bus_b.o_in_ready, 4'b0010);
      tick();
      check("b_fp_sel", bus_b.o_out_sel, 1);
      check("b_fp_count", bus_b.o_grant_count, k + 1);
    end
    bus_b.i_in_valid = 4'h0;
    tick();

    // 3-channel wrap: ch2 alone, then all three -> 0,1,2
    bus_c.i_in_data = {8'hC2, 8'hC1, 8'hC0};
    bus_c.i_in_valid = 3'b100;
    q_c.push_back({6'd0, 2'd2, 8'hC2});
    #1;
    check("c_first_in_ready", bus_c.o_in_ready, 3'b100);
    tick();
    check("c_first_sel", bus_c.o_out_sel, 2);
    bus_c.i_in_valid = 3'b111;
    for (int k = 0; k < 3; k++) q_c.push_back({6'd0, 2'(k), 8'hC0 + 8'(k)});
    for (int k = 0; k < 3; k++) begin
      tick();
      check("c_wrap_sel", bus_c.o_out_sel, k);
    end
    bus_c.i_in_valid = 3'b000;
    repeat (3) tick();

    check("a_queue_empty", q_a.size(), 0);
    check("b_queue_empty", q_b.size(), 0);
    check("c_queue_empty", q_c.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter WIDTH, default 8: data width of each channel, >=1.
REQ-002 Parameter CHANNELS, default 4: number of input channels, >=2, need not be a power of two.
REQ-003 Parameter MODE, default 1: 1 = round-robin arbitration, 0 = fixed priority with lowest index winning.
REQ-004 Localparam SEL_W = clog2(CHANNELS).
REQ-005 clk_  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n_  input  1  reset, asynchronous, active-low.
REQ-007 in_data_  input  CHANNELS*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
REQ-008 in_valid_  input  CHANNELS  per-channel valid.
REQ-009 in_ready_  output  CHANNELS  per-channel ready, at most one bit high.
REQ-010 out_data_  output  WIDTH  registered selected word.
REQ-011 out_valid_  output  1  out_data_ holds a word.
REQ-012 out_ready_  input  1  downstream accepts the word.
REQ-013 out_sel_  output  SEL_W  channel index of the word in out_data_.
REQ-014 grant_count_  output  16  running count of accepted input transfers.

Function
REQ-015 load = !out_valid_ || out_ready_, combinational.
REQ-016 The winner is computed combinationally from in_valid_ and the rotation pointer ptr (SEL_W bits).
REQ-017 in_ready_[i] = load && any(in_valid_) && (i == winner); all other bits are 0.
REQ-018 An input transfer on channel i occurs when in_valid_[i] && in_ready_[i] at a rising edge.
REQ-019 On a transfer: out_data_ <= winner's data, out_sel_ <= winner, out_valid_ <= 1; latency is 1 cycle from the accepting edge.
REQ-020 When load is true and in_valid_ is all 0: out_valid_ <= 0; out_data_ and out_sel_ hold.
REQ-021 When out_valid_ && !out_ready_: out_data_, out_sel_ and out_valid_ hold, and in_ready_ is all 0.
REQ-022 Simultaneous drain and fill (out_valid_ && out_ready_ && any in_valid_): the new word replaces the old at the same edge, with no bubble.
REQ-023 MODE=1: search starts at ptr, ascending, wrapping from CHANNELS-1 to 0; the first valid channel wins.
REQ-024 MODE=1: after a transfer from winner w, ptr <= (w == CHANNELS-1) ? 0 : w+1; without a transfer, ptr holds.
REQ-025 MODE=0: the lowest-index valid channel wins; ptr stays 0.
REQ-026 grant_count_ increments by 1 per transfer, wrapping 16'hFFFF -> 0; without a transfer it holds.
REQ-027 Input data values are don't-care when the corresponding valid bit is 0; X on those bits shall not propagate to the outputs.

Reset
REQ-028 rst_n_ low clears out_valid_, out_data_, out_sel_, ptr and grant_count_ to 0 immediately, independent of clk_.
REQ-029 While rst_n_ is low, in_ready_ is all 0 and no transfer occurs.
REQ-030 Reset mid-operation discards any held word; the first transfer after release starts arbitration at channel 0.

Verification
REQ-031 Reset mid-hold: out_valid_=1, out_ready_=0, rst_n_ driven low between edges -> out_valid_=0 and grant_count_=0 before the next clk_ edge; in_ready_=0.
REQ-032 Round-robin fairness: MODE=1, CHANNELS=4, in_valid_=4'b1111, out_ready_=1 held -> out_sel_ sequence 0,1,2,3,0,1; grant_count_ +1 every cycle.
REQ-033 Backpressure: word A held with out_ready_=0 for 3 cycles -> out_data_=A stable and in_ready_=0; raising out_ready_ loads the next word B at that same edge (no bubble).
REQ-034 Fixed priority: MODE=0, in_valid_=4'b1010 constant, out_ready_=1 -> out_sel_=1 every cycle; in_ready_[3] never high.
REQ-035 Non-power-of-two wrap: MODE=1, CHANNELS=3; first in_valid_=3'b100 only (grant ch2, ptr->0), then 3'b111 -> next out_sel_ sequence 0,1,2.
REQ-036 Counter wrap: 65536 consecutive transfers from reset -> grant_count_ reads 0; transfer 65537 -> reads 1.
